// File: rtl/memory_stage_pkg.sv
// Shared types for the M stage: widths, access FSM states and the W-register bundle.
// The misalign field exists only when MEM_MISALIGN_CHECK_EN is defined.
package memory_stage_pkg;

  localparam int WORD     = 32;
  localparam int REG_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RESP
  } mem_state_t;

  typedef struct packed {
    logic                valid;
    logic                regWrite;
    logic [WORD-1:0]     result;
    logic [REG_SIZE-1:0] writeReg;
    logic [WORD-1:0]     pc;
`ifdef MEM_MISALIGN_CHECK_EN
    logic                misalign;
`endif
  } wb_bundle_t;

endpackage

// File: rtl/memory_stage_flopenr.sv
// Parameterised enable register with asynchronous active-low reset to zero.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline M stage: issues loads/stores over req/gnt + rvalid, stalls upstream while busy,
// and fills the W register. Optional MEM_MISALIGN_CHECK_EN rejects unaligned memory ops.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DMEM_ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   validM,
  input  logic [WORD-1:0]        ALUResultM,
  input  logic [WORD-1:0]        writeDataM,
  input  logic [WORD-1:0]        pcM,
  input  logic [REG_SIZE-1:0]    writeRegM,
  input  logic                   regWriteM,
  input  logic                   memWriteM,
  input  logic                   mem2regM,
  output logic                   stallM,
  output logic                   dmemReq,
  output logic                   dmemWe,
  output logic [DMEM_ADDR_W-1:0] dmemAddr,
  output logic [WORD-1:0]        dmemWdata,
  input  logic                   dmemGnt,
  input  logic                   dmemRvalid,
  input  logic [WORD-1:0]        dmemRdata,
  output logic                   validW,
  output logic                   regWriteW,
  output logic [WORD-1:0]        resultW,
  output logic [REG_SIZE-1:0]    writeRegW,
  output logic [WORD-1:0]        pcW
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                   misalignW
`endif
);

  mem_state_t state_reg, state_next;
  wb_bundle_t wb_reg, wb_next;
  logic       mem_op;
  logic       misalign;
  logic       issue;
  logic       retire;

  assign mem_op = validM && (memWriteM || mem2regM);
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = mem_op && (ALUResultM[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign issue = mem_op && !misalign;

  // memWriteM wins when both memory controls are set, so a plain store check suffices.
  assign dmemReq   = issue && (state_reg != WAIT_RESP);
  assign dmemWe    = validM && memWriteM;
  assign dmemAddr  = ALUResultM[DMEM_ADDR_W-1:0];
  assign dmemWdata = writeDataM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!issue) begin
          retire = 1'b1;
        end else if (dmemGnt) begin
          if (memWriteM) retire = 1'b1;
          else           state_next = WAIT_RESP;
        end else begin
          state_next = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (dmemGnt) begin
          if (memWriteM) begin
            retire     = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (dmemRvalid) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stallM = !retire;

  // Non-retire cycles push a bubble: valid bits cleared, payload fields hold.
  always_comb begin
    wb_next          = wb_reg;
    wb_next.valid    = 1'b0;
    wb_next.regWrite = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    wb_next.misalign = 1'b0;
`endif
    if (retire) begin
      wb_next.valid    = validM;
      wb_next.regWrite = validM && regWriteM && !misalign;
      wb_next.result   = mem2regM ? dmemRdata : ALUResultM;
      wb_next.writeReg = writeRegM;
      wb_next.pc       = pcM;
`ifdef MEM_MISALIGN_CHECK_EN
      wb_next.misalign = misalign;
`endif
    end
  end

  flopenr #(
    .WIDTH($bits(wb_bundle_t))
  ) u_wb_reg (
    .clk  (clk),
    .reset(reset),
    .en   (1'b1),
    .d    (wb_next),
    .q    (wb_reg)
  );

  assign validW    = wb_reg.valid;
  assign regWriteW = wb_reg.regWrite;
  assign resultW   = wb_reg.result;
  assign writeRegW = wb_reg.writeReg;
  assign pcW       = wb_reg.pc;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalignW = wb_reg.misalign;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Table-driven bench for memory_stage with a W-stage scoreboard plus hand-written reset sequence.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                validM = 1'b0;
  logic [WORD-1:0]     ALUResultM = '0;
  logic [WORD-1:0]     writeDataM = '0;
  logic [WORD-1:0]     pcM = '0;
  logic [REG_SIZE-1:0] writeRegM = '0;
  logic                regWriteM = 1'b0;
  logic                memWriteM = 1'b0;
  logic                mem2regM = 1'b0;
  logic                stallM;
  logic                dmemReq;
  logic                dmemWe;
  logic [31:0]         dmemAddr;
  logic [WORD-1:0]     dmemWdata;
  logic                dmemGnt = 1'b0;
  logic                dmemRvalid = 1'b0;
  logic [WORD-1:0]     dmemRdata = GARBAGE;
  logic                validW;
  logic                regWriteW;
  logic [WORD-1:0]     resultW;
  logic [REG_SIZE-1:0] writeRegW;
  logic [WORD-1:0]     pcW;
`ifdef MEM_MISALIGN_CHECK_EN
  logic                misalignW;
`endif

  memory_stage #(.DMEM_ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .validM(validM), .ALUResultM(ALUResultM),
    .writeDataM(writeDataM), .pcM(pcM), .writeRegM(writeRegM),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .mem2regM(mem2regM),
    .stallM(stallM), .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemWdata(dmemWdata), .dmemGnt(dmemGnt), .dmemRvalid(dmemRvalid),
    .dmemRdata(dmemRdata), .validW(validW), .regWriteW(regWriteW),
    .resultW(resultW), .writeRegW(writeRegW), .pcW(pcW)
`ifdef MEM_MISALIGN_CHECK_EN
    , .misalignW(misalignW)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw, mw, m2r;
    int          gnt_delay;
    int          rv_delay;
    logic [31:0] rdata;
    int          exp_stalls;
    int          exp_reqs;
    logic        exp_rw;
    logic [31:0] exp_result;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [31:0] result;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // W-stage monitor: every valid retire must match the oldest expected record.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      if (validW) begin
        if (sb.size() == 0) begin
          chk("unexpected_validW", 32'(validW), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("regWriteW", 32'(regWriteW), 32'(e.rw));
          chk("resultW", resultW, e.result);
          chk("writeRegW", 32'(writeRegW), 32'(e.rd));
          chk("pcW", pcW, e.pc);
`ifdef MEM_MISALIGN_CHECK_EN
          chk("misalignW", 32'(misalignW), 32'(e.mis));
`endif
          $display("retire pc=%h rd=%0d result=%h rw=%0b", pcW, writeRegW, resultW, regWriteW);
        end
      end else begin
        chk("bubble_regWriteW", 32'(regWriteW), 32'd0);
      end
    end
  end

  task automatic do_txn(input int idx, input vec_t v);
    int   stalls = 0;
    int   reqs = 0;
    bit   granted = 0;
    int   since = 0;
    bit   done = 0;
    bit   gnt_now;
    bit   st;
    exp_t e;
    validM = 1'b1; ALUResultM = v.alu; writeDataM = v.wdata; pcM = v.pc;
    writeRegM = v.rd; regWriteM = v.rw; memWriteM = v.mw; mem2regM = v.m2r;
    e = '{rw: v.exp_rw, result: v.exp_result, rd: v.rd, pc: v.pc, mis: v.exp_mis};
    sb.push_back(e);
    for (int cyc = 0; cyc < 60; cyc++) begin
      gnt_now    = (v.mw || v.m2r) && !granted && (cyc >= v.gnt_delay);
      dmemGnt    = gnt_now;
      dmemRvalid = granted && (since == v.rv_delay);
      dmemRdata  = dmemRvalid ? v.rdata : GARBAGE;
      #1;
      st = stallM;
      if (st) stalls++;
      if (dmemReq) begin
        reqs++;
        chk("dmemAddr", dmemAddr, v.alu);
        chk("dmemWdata", dmemWdata, v.wdata);
        chk("dmemWe", 32'(dmemWe), 32'(v.mw));
      end
      @(posedge clk); #1;
      if (gnt_now) begin
        granted = 1;
        since = 1;
      end else if (granted) begin
        since++;
      end
      if (!st) begin
        done = 1;
        break;
      end
    end
    dmemGnt = 1'b0; dmemRvalid = 1'b0; dmemRdata = GARBAGE;
    chk("txn_completed", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(v.exp_stalls));
    chk("req_cycles", 32'(reqs), 32'(v.exp_reqs));
    $display("txn %0d addr=%h stalls=%0d reqs=%0d", idx, v.alu, stalls, reqs);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //          alu           wdata         pc            rd  rw mw m2r gd rv rdata          st rq erw eresult        mis
    vecs[0] = '{32'h0000_002A, 32'h0,       32'h0000_1000, 5,  1, 0, 0, 0, 0, 32'h0,         0, 0, 1, 32'h0000_002A, 0};
    vecs[1] = '{32'h0000_0100, 32'h0,       32'h0000_1004, 7,  1, 0, 1, 0, 4, 32'hDEAD_BEEF, 4, 1, 1, 32'hDEAD_BEEF, 0};
    vecs[2] = '{32'h0000_0200, 32'h1234,    32'h0000_1008, 2,  0, 1, 0, 2, 0, 32'h0,         2, 3, 0, 32'h0000_0200, 0};
    vecs[3] = '{32'h0000_0300, 32'h0,       32'h0000_100C, 9,  1, 0, 1, 0, 1, 32'hCAFE_F00D, 1, 1, 1, 32'hCAFE_F00D, 0};
    vecs[4] = '{32'h0000_0055, 32'h0,       32'h0000_1010, 10, 1, 0, 0, 0, 0, 32'h0,         0, 0, 1, 32'h0000_0055, 0};
    vecs[5] = '{32'h0000_0400, 32'h0,       32'h0000_1014, 3,  1, 0, 1, 1, 2, 32'h0BAD_F00D, 3, 2, 1, 32'h0BAD_F00D, 0};
    vecs[6] = '{32'h0000_0404, 32'h77,      32'h0000_1018, 6,  0, 1, 0, 0, 0, 32'h0,         0, 1, 0, 32'h0000_0404, 0};
    vecs[7] = '{32'h0000_0408, 32'h88,      32'h0000_101C, 8,  0, 1, 1, 1, 0, 32'h0,         1, 2, 0, GARBAGE,       0};
`ifdef MEM_MISALIGN_CHECK_EN
    vecs[8] = '{32'h0000_0102, 32'h0,       32'h0000_1020, 11, 1, 0, 1, 0, 1, 32'h1122_3344, 0, 0, 0, GARBAGE,       1};
`else
    vecs[8] = '{32'h0000_0102, 32'h0,       32'h0000_1020, 11, 1, 0, 1, 0, 1, 32'h1122_3344, 1, 1, 1, 32'h1122_3344, 0};
`endif
    vecs[9] = '{32'h0000_0099, 32'h0,       32'h0000_1024, 4,  0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0000_0099, 0};

    #12;
    chk("rst_validW", 32'(validW), 32'd0);
    chk("rst_regWriteW", 32'(regWriteW), 32'd0);
    chk("rst_resultW", resultW, 32'd0);
    chk("rst_writeRegW", 32'(writeRegW), 32'd0);
    chk("rst_pcW", pcW, 32'd0);
    chk("rst_dmemReq", 32'(dmemReq), 32'd0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) do_txn(i, vecs[i]);
    validM = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while a load waits for its response; late rvalid must be ignored.
    validM = 1'b1; ALUResultM = 32'h0000_0500; pcM = 32'h0000_2000; writeRegM = 5'd12;
    regWriteM = 1'b1; memWriteM = 1'b0; mem2regM = 1'b1; dmemGnt = 1'b1;
    #1 chk("rs_req_idle", 32'(dmemReq), 32'd1);
    @(posedge clk); #1;
    dmemGnt = 1'b0;
    #1;
    chk("rs_stall_wresp", 32'(stallM), 32'd1);
    chk("rs_req_wresp", 32'(dmemReq), 32'd0);
    validM = 1'b0;
    reset = 1'b0;
    #1;
    chk("rs_validW", 32'(validW), 32'd0);
    chk("rs_regWriteW", 32'(regWriteW), 32'd0);
    chk("rs_resultW", resultW, 32'd0);
    chk("rs_writeRegW", 32'(writeRegW), 32'd0);
    chk("rs_pcW", pcW, 32'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-access applied and released");

    validM = 1'b1; ALUResultM = 32'h0000_0600; pcM = 32'h0000_2004; writeRegM = 5'd13;
    dmemRvalid = 1'b1; dmemRdata = 32'h5151_5151;
    #1;
    chk("stray_stall_idle", 32'(stallM), 32'd1);
    chk("stray_req_idle", 32'(dmemReq), 32'd1);
    @(posedge clk); #1;
    chk("stray_stall_wgnt", 32'(stallM), 32'd1);
    chk("stray_req_wgnt", 32'(dmemReq), 32'd1);
    sb.push_back('{rw: 1'b1, result: 32'h600D_600D, rd: 5'd13, pc: 32'h0000_2004, mis: 1'b0});
    dmemRvalid = 1'b0; dmemGnt = 1'b1;
    @(posedge clk); #1;
    dmemGnt = 1'b0; dmemRvalid = 1'b1; dmemRdata = 32'h600D_600D;
    #1 chk("stray_retire_stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    validM = 1'b0; dmemRvalid = 1'b0; dmemRdata = GARBAGE;
    $display("post-reset load issued after stray rvalid");
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
